irom_loader: RTL

- Boot-time program loader and the write side of the instruction ROM.
- Accepts a framed byte stream from a host link (UART receiver or testbench) and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into IROM and drives the core-wide `setup` level, which holds the core in load mode until a verified image is in place.
- On checksum match it releases `setup` so the core fetches from the first address.

---
 rtl/irom_loader_if.sv | 24 ++
 rtl/irom_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/irom_loader_if.sv
// irom_loader_if: host byte stream, reload request, IROM write port and load status
interface irom_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              load_req;
    logic              setup;
    logic              irom_wr_en;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              load_done;
    logic              load_err;
    modport slave (
        input  rx_data, rx_valid, load_req,
        output rx_ready, setup, irom_wr_en, irom_addr, irom_wdata, words_loaded, load_done, load_err
    );
    modport master (
        output rx_data, rx_valid, load_req,
        input  rx_ready, setup, irom_wr_en, irom_addr, irom_wdata, words_loaded, load_done, load_err
    );
endinterface

// File: rtl/irom_loader.sv
// irom_loader: framed byte stream to IROM writer with XOR checksum gating the setup release
module irom_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input logic          clk,
    input logic          rst,
    irom_loader_if.slave bus_if
);
    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
    localparam logic [32:0]       DEPTH = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rx_ready;
    logic              fire;
    logic [31:0]       n_new;
    logic [7:0]        d;
    assign d        = bus_if.rx_data;
    assign rx_ready = !rst && (state_q == HDR || state_q == DATA || state_q == CSUM);
    assign fire     = bus_if.rx_valid && rx_ready;
    assign n_new    = {d, n_q[31:8]};
    assign bus_if.rx_ready     = rx_ready;
    assign bus_if.setup        = rst || state_q != DONE;
    assign bus_if.load_done    = !rst && state_q == DONE;
    assign bus_if.load_err     = !rst && state_q == ERR;
    assign bus_if.irom_wr_en   = !rst && wr_q;
    assign bus_if.irom_addr    = rst ? BASE : addr_q;
    assign bus_if.irom_wdata   = rst ? 32'd0 : wdata_q;
    assign bus_if.words_loaded = rst ? '0 : wl_q;
    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR;
            n_q     <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            wl_q    <= '0;
            addr_q  <= BASE;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            wl_q    <= wl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end
    // frame parsing: header count, word assembly with one-cycle-late write strobe, checksum verdict
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        wl_d    = wl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        case (state_q)
            HDR: if (fire) begin
                n_d   = n_new;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = ({1'b0, n_new} > DEPTH) ? ERR : (n_new == 32'd0) ? CSUM : DATA;
            end
            DATA: if (fire) begin
                csum_d = csum_q ^ d;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    wr_d    = 1'b1;
                    wdata_d = {d, asm_q};
                    addr_d  = BASE + wl_q[ADDR_W-1:0];
                    wl_d    = wl_q + 1'b1;
                    if (32'(wl_q) + 32'd1 == n_q)
                        state_d = CSUM;
                end else begin
                    asm_d = (idx_q == 2'd0) ? {asm_q[23:8], d} :
                            (idx_q == 2'd1) ? {asm_q[23:16], d, asm_q[7:0]} :
                                              {d, asm_q[15:0]};
                end
            end
            CSUM: if (fire)
                state_d = (d == csum_q) ? DONE : ERR;
            default: if (bus_if.load_req) begin
                state_d = HDR;
                n_d     = '0;
                idx_d   = '0;
                asm_d   = '0;
                csum_d  = '0;
                wl_d    = '0;
                addr_d  = BASE;
            end
        endcase
    end
endmodule
